i2c_master_ctrl: RTL and testbench

- Single-transaction I2C initiator: the controller-side counterpart of the on-chip I2C register responder.
- Issues one 8-bit-address register write or read to an external or looped-back I2C responder.
- Used for bench loopback against the on-chip responder and for driving external I2C peripherals (LED drivers, sensors) from system logic.
- Drives open-drain SCL/SDA through enable outputs; pad tristating is handled at a higher level.

---
 rtl/i2c_master_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C initiator: one 8-bit-address register write or read.
// Define I2CM_STRETCH_EN to let the responder stretch SCL at every released-SCL quarter Q2.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CntMax = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddrW, StReg, StWdata, StRstart,
    StAddrR, StRdata, StMnack, StStop, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          nack_q, nack_d;
  logic          ack_err_q, ack_err_d;

  logic       active, q_end, smp, hold;
  logic [7:0] tx_byte;

  assign active  = (state_q != StIdle) && (state_q != StDone);
  assign q_end   = (cnt_q == CntMax) && (qtr_q == 2'd3);
  assign smp     = (cnt_q == CntMax) && (qtr_q == 2'd2);
  assign busy    = active;
  assign rdata   = rdata_q;
  assign ack_err = ack_err_q;

`ifdef I2CM_STRETCH_EN
  // SCL is released in Q2 of every phase, so a low scl_in there means the responder holds it.
  assign hold = active && (qtr_q == 2'd2) && (cnt_q == '0) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  always_comb begin
    tx_byte = reg_q;
    case (state_q)
      StAddrW: tx_byte = {dev_q, 1'b0};
      StWdata: tx_byte = wdata_q;
      StAddrR: tx_byte = {dev_q, 1'b1};
      default: tx_byte = reg_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    done      = 1'b0;

    if (active && !hold) begin
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      StStart: if (q_end) state_d = StAddrW;
      StAddrW, StReg, StWdata, StAddrR: begin
        if (smp && bit_q == 4'd8) nack_d = sda_in;
        if (q_end) begin
          if (bit_q == 4'd8) begin
            bit_d = '0;
            if (nack_q) state_d = StStop;
            else begin
              case (state_q)
                StAddrW: state_d = StReg;
                StReg:   state_d = rw_q ? StRstart : StWdata;
                StWdata: state_d = StStop;
                default: state_d = StRdata;
              endcase
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StRstart: if (q_end) state_d = StAddrR;
      StRdata: begin
        if (smp) rdata_d = {rdata_q[6:0], sda_in};
        if (q_end) begin
          if (bit_q == 4'd7) begin
            bit_d   = '0;
            state_d = StMnack;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StMnack: if (q_end) state_d = StStop;
      StStop: begin
        if (q_end) begin
          state_d   = StDone;
          ack_err_d = nack_q;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: ;
    endcase

    if (!active && start) begin
      state_d   = StStart;
      cnt_d     = '0;
      qtr_d     = '0;
      bit_d     = '0;
      rw_d      = rw;
      dev_d     = dev_addr;
      reg_d     = reg_addr;
      wdata_d   = wdata;
      nack_d    = 1'b0;
      ack_err_d = 1'b0;
    end
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      StStart: begin
        scl_oe = (qtr_q == 2'd3);
        sda_oe = qtr_q[1];
      end
      StAddrW, StReg, StWdata, StAddrR: begin
        scl_oe = !qtr_q[1];
        sda_oe = (bit_q != 4'd8) && !tx_byte[~bit_q[2:0]];
      end
      StRdata, StMnack: scl_oe = !qtr_q[1];
      StRstart: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = qtr_q[1];
      end
      StStop: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = !qtr_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bit-level I2C responder model watches the open-drain bus,
// and expected bytes, durations and flags are derived from the transaction description.
module tb_i2c_master_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int PH = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  logic       scl_in, sda_in, scl_oe, sda_oe;

  // Responder model state
  logic       resp_pull = 1'b0;
  int         stretch_cnt = 0;
  bit         stretch_req = 1'b0;
  int         bit_i = 0, seg_byte = 0, wr_idx = 0, nack_at = -1;
  int         starts = 0, stops = 0;
  logic       seg_read = 1'b0, mnack_bit = 1'b0;
  logic [7:0] shreg = '0, rd_val = '0;
  logic [7:0] bytes_q[$];

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] exp_rdata = '0;

  assign scl_in = ~scl_oe & ~(stretch_cnt > 0);
  assign sda_in = ~sda_oe & ~resp_pull;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: samples on SCL rise, changes SDA on SCL fall, ACKs master bytes unless told not to.
  initial begin
    logic scl, sda, scl_p, sda_p, scl_oe_p;
    scl_p = 1'b1; sda_p = 1'b1; scl_oe_p = 1'b0;
    forever begin
      @(negedge clk);
      if (stretch_cnt > 0) stretch_cnt--;
      else if (stretch_req && scl_oe_p && !scl_oe && bit_i == 8) begin
        stretch_cnt = 10;
        stretch_req = 1'b0;
      end
      scl = ~scl_oe & ~(stretch_cnt > 0);
      sda = ~sda_oe & ~resp_pull;
      scl_oe_p = scl_oe;
      if (scl && scl_p && sda_p && !sda) begin
        starts++; bit_i = 0; seg_byte = 0; seg_read = 1'b0;
      end else if (scl && scl_p && !sda_p && sda) begin
        stops++;
      end else if (scl && !scl_p) begin
        if (bit_i < 8) begin
          shreg = {shreg[6:0], sda};
          bit_i++;
          if (bit_i == 8) begin
            bytes_q.push_back(shreg);
            if (seg_byte == 0) seg_read = shreg[0];
          end
        end else begin
          if (seg_read && seg_byte == 1) mnack_bit = sda;
          else wr_idx++;
          bit_i = 0;
          seg_byte++;
        end
      end else if (!scl && scl_p) begin
        if (bit_i == 8) resp_pull = !(seg_read && seg_byte == 1) && (wr_idx != nack_at);
        else if (seg_read && seg_byte == 1) resp_pull = !rd_val[7-bit_i];
        else resp_pull = 1'b0;
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  task automatic do_txn(input string tag, input logic rw_i, input logic [6:0] dev,
                        input logic [7:0] ra, input logic [7:0] wd, input logic [7:0] rv,
                        input int nk, input bit poke, input int extra);
    logic [7:0] exp_b[$];
    int nb, exp_busy, n, guard;
    bit sr;
    exp_b.push_back({dev, 1'b0});
    exp_b.push_back(ra);
    if (rw_i) begin
      exp_b.push_back({dev, 1'b1});
      exp_b.push_back(rv);
    end else begin
      exp_b.push_back(wd);
    end
    nb = (nk >= 0) ? nk + 1 : exp_b.size();
    sr = rw_i && nb >= 3;
    exp_busy = (2 + 9 * nb + (sr ? 1 : 0)) * PH + extra;
    if (rw_i && nk < 0) exp_rdata = rv;

    bytes_q.delete();
    starts = 0; stops = 0; wr_idx = 0; nack_at = nk; rd_val = rv; mnack_bit = 1'b0;

    rw = rw_i; dev_addr = dev; reg_addr = ra; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy_rise"}, 32'(busy), 32'd1);
    n = 0;
    guard = 0;
    while (!done && guard < 4000) begin
      if (busy) n++;
      if (poke && guard == 100) begin
        start = 1'b1; rw = ~rw_i; dev_addr = dev ^ 7'h2A; reg_addr = ~ra; wdata = ~wd;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (!done) begin
      check({tag, ":done_timeout"}, 32'(done), 32'd1);
    end else begin
      check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
      check({tag, ":busy_cycles"}, 32'(n), 32'(exp_busy));
      check({tag, ":ack_err"}, 32'(ack_err), 32'(nk >= 0));
      check({tag, ":rdata"}, 32'(rdata), 32'(exp_rdata));
      check({tag, ":starts"}, 32'(starts), sr ? 32'd2 : 32'd1);
      check({tag, ":stops"}, 32'(stops), 32'd1);
      check({tag, ":nbytes"}, 32'(bytes_q.size()), 32'(nb));
      for (int i = 0; i < nb && i < bytes_q.size(); i++)
        check({tag, $sformatf(":byte%0d", i)}, 32'(bytes_q[i]), 32'(exp_b[i]));
      if (rw_i && nk < 0) check({tag, ":mnack"}, 32'(mnack_bit), 32'd1);
      @(negedge clk);
      check({tag, ":done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst:scl_oe", 32'(scl_oe), 32'd0);
    check("rst:sda_oe", 32'(sda_oe), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:ack_err", 32'(ack_err), 32'd0);
    check("rst:rdata", 32'(rdata), 32'd0);

    do_txn("write", 1'b0, 7'h48, 8'h05, 8'hA5, 8'h00, -1, 1'b0, 0);
    do_txn("read", 1'b1, 7'h48, 8'h02, 8'h00, 8'h3C, -1, 1'b0, 0);
    do_txn("noresp", 1'b1, 7'h48, 8'h02, 8'h00, 8'hC3, 0, 1'b0, 0);
    do_txn("poke", 1'b0, 7'h21, 8'h7E, 8'h18, 8'h00, -1, 1'b1, 0);

    // Reset in the middle of the register byte
    rw = 1'b0; dev_addr = 7'h48; reg_addr = 8'h05; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14 * PH) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst:scl_oe", 32'(scl_oe), 32'd0);
    check("midrst:sda_oe", 32'(sda_oe), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    reset = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    check("midrst:done2", 32'(done), 32'd0);
    do_txn("after_rst", 1'b0, 7'h48, 8'h05, 8'hA5, 8'h00, -1, 1'b0, 0);

    for (int t = 0; t < 10; t++) begin
      int r;
      r = int'($urandom_range(0, 5));
      do_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 7'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), (r >= 3) ? -1 : r, 1'b0, 0);
    end

`ifdef I2CM_STRETCH_EN
    stretch_req = 1'b1;
    do_txn("stretch", 1'b0, 7'h48, 8'h05, 8'hA5, 8'h00, -1, 1'b0, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
